// File: rtl/pe_au_pkg.sv
// Shared opcode encoding and default datapath widths for the PE arithmetic unit.
package pe_au_pkg;

    localparam int DEF_A_W   = 27;
    localparam int DEF_B_W   = 18;
    localparam int DEF_P_W   = 48;
    localparam int DEF_SHIFT = 17;

    typedef enum logic [2:0] {
        OP_MUL            = 3'd0,
        OP_MUL_ADD_C      = 3'd1,
        OP_MUL_ADD_PCIN   = 3'd2,
        OP_MUL_ACC        = 3'd3,
        OP_MUL_ACC_SHIFT  = 3'd4,
        OP_PCIN_SHIFT_ADD = 3'd5,
        OP_CLEAR          = 3'd6,
        OP_RESERVED       = 3'd7
    } op_e;

endpackage

// File: rtl/pe_delay_line.sv
// Clock-enabled shift register of configurable depth; depth 0 degenerates to a wire.
module pe_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clock_i, reset_n_i, ce_i};
        assign q_o = d_i;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (ce_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/pe_au_pipe.sv
// Pipelined signed multiply/accumulate PE with per-operation opcode, valid tag,
// clock enable and a shifted cascade path for chaining column accumulators.
module pe_au_pipe
    import pe_au_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int P_W   = DEF_P_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int ABREG = 1,
    parameter int MREG  = 1
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    input  logic           ce_i,
    input  logic           valid_i,
    input  logic [2:0]     op_i,
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    input  logic [P_W-1:0] c_i,
    input  logic [P_W-1:0] pcin_i,
    output logic [P_W-1:0] p_o,
    output logic [P_W-1:0] pcout_o,
    output logic           valid_o
);

    if (P_W < A_W + B_W || SHIFT < 1 || SHIFT > P_W - 1 ||
        ABREG < 0 || ABREG > 2 || MREG < 0 || MREG > 1) begin : g_param_check
        $fatal(1, "pe_au_pipe: parameter combination out of range");
    end

    localparam int DLY = ABREG + MREG;

    logic [A_W-1:0]        a_d;
    logic [B_W-1:0]        b_d;
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] m_comb;
    logic signed [P_W-1:0] m_d;
    logic signed [P_W-1:0] c_d;
    logic signed [P_W-1:0] pcin_s;
    logic [3:0]            tag_d;
    logic                  tag_valid;
    op_e                   tag_op;
    logic signed [P_W-1:0] p_q;
    logic signed [P_W-1:0] p_next;
    logic                  valid_q;

    pe_delay_line #(.DEPTH(ABREG), .WIDTH(A_W)) u_a_dly (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .d_i(a_i), .q_o(a_d)
    );

    pe_delay_line #(.DEPTH(ABREG), .WIDTH(B_W)) u_b_dly (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .d_i(b_i), .q_o(b_d)
    );

    // Operands are sign-extended first so the P_W-wide product is exact.
    assign a_ext  = P_W'($signed(a_d));
    assign b_ext  = P_W'($signed(b_d));
    assign m_comb = a_ext * b_ext;

    pe_delay_line #(.DEPTH(MREG), .WIDTH(P_W)) u_m_dly (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .d_i(m_comb), .q_o(m_d)
    );

    pe_delay_line #(.DEPTH(DLY), .WIDTH(P_W)) u_c_dly (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .d_i(c_i), .q_o(c_d)
    );

    pe_delay_line #(.DEPTH(DLY), .WIDTH(4)) u_tag_dly (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i),
        .d_i({valid_i, op_i}), .q_o(tag_d)
    );

    assign tag_valid = tag_d[3];
    assign tag_op    = op_e'(tag_d[2:0]);
    assign pcin_s    = $signed(pcin_i);

    // Feedback comes from the P register itself, so MUL_ACC can issue every cycle.
    always_comb begin
        p_next = m_d;
        case (tag_op)
            OP_MUL_ADD_C:      p_next = m_d + c_d;
            OP_MUL_ADD_PCIN:   p_next = m_d + pcin_s;
            OP_MUL_ACC:        p_next = p_q + m_d;
            OP_MUL_ACC_SHIFT:  p_next = (p_q >>> SHIFT) + m_d;
            OP_PCIN_SHIFT_ADD: p_next = (pcin_s >>> SHIFT) + m_d;
            OP_CLEAR:          p_next = '0;
            default:           p_next = m_d;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else if (ce_i) begin
            valid_q <= tag_valid;
            if (tag_valid) p_q <= p_next;
        end
    end

    assign p_o     = p_q;
    assign pcout_o = p_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_pe_au_pipe.sv
// Randomised, model-checked bench for pe_au_pipe: directed scenarios, cascade,
// stall/reset control, latency sweep over pipeline depths and a random mix.
module tb_pe_au_pipe;

    logic        clock;
    logic        reset_n;
    logic        ce;
    logic        valid;
    logic [2:0]  op;
    logic signed [26:0] a;
    logic signed [17:0] b;
    logic signed [47:0] c;
    logic signed [47:0] p;
    logic signed [47:0] pcout;
    logic        valid_o;

    logic        up_valid;
    logic [2:0]  up_op;
    logic signed [26:0] up_a;
    logic signed [17:0] up_b;
    logic signed [47:0] up_p;
    logic signed [47:0] up_pcout;
    logic        up_valid_o;

    logic               sw_v  [6];
    logic signed [47:0] sw_p  [6];
    logic signed [47:0] sw_pc [6];

    int checks = 0;
    int errors = 0;

    pe_au_pipe u_up (
        .clock_i(clock), .reset_n_i(reset_n), .ce_i(ce), .valid_i(up_valid), .op_i(up_op),
        .a_i(up_a), .b_i(up_b), .c_i(48'd0), .pcin_i(48'd0),
        .p_o(up_p), .pcout_o(up_pcout), .valid_o(up_valid_o)
    );

    pe_au_pipe u_dut (
        .clock_i(clock), .reset_n_i(reset_n), .ce_i(ce), .valid_i(valid), .op_i(op),
        .a_i(a), .b_i(b), .c_i(c), .pcin_i(up_pcout),
        .p_o(p), .pcout_o(pcout), .valid_o(valid_o)
    );

    for (genvar gi = 0; gi < 6; gi++) begin : g_sweep
        pe_au_pipe #(.ABREG(gi / 2), .MREG(gi % 2)) u_sw (
            .clock_i(clock), .reset_n_i(reset_n), .ce_i(ce), .valid_i(valid), .op_i(op),
            .a_i(a), .b_i(b), .c_i(c), .pcin_i(48'd0),
            .p_o(sw_p[gi]), .pcout_o(sw_pc[gi]), .valid_o(sw_v[gi])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural opcode semantics on 64-bit integers, wrapped to 48 bits.
    function automatic logic signed [47:0] ref_op(input int opc, input longint av, input longint bv,
                                                  input longint cv, input longint pc, input longint pp);
        longint m;
        longint r;
        logic signed [47:0] res;
        m = av * bv;
        case (opc)
            1:       r = m + cv;
            2:       r = m + pc;
            3:       r = pp + m;
            4:       r = (pp >>> 17) + m;
            5:       r = (pc >>> 17) + m;
            6:       r = 0;
            default: r = m;
        endcase
        res = r[47:0];
        return res;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [2:0] opv, input logic signed [26:0] av, input logic signed [17:0] bv,
                          input logic signed [47:0] cv, output logic signed [47:0] got, output int lat);
        op = opv; a = av; b = bv; c = cv; valid = 1'b1;
        tick();
        valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            if (valid_o === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
        got = p;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce = 1'b1; valid = 1'b0; op = '0; a = '0; b = '0; c = '0;
        up_valid = 1'b0; up_op = '0; up_a = '0; up_b = '0;
        tick(); tick();
        checks++; if (p !== 48'sd0) begin errors++; $display("[TB] FAIL reset_p: got %0d expected 0", p); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (pcout !== 48'sd0) begin errors++; $display("[TB] FAIL reset_pcout: got %0d expected 0", pcout); end
        checks++; if (up_p !== 48'sd0) begin errors++; $display("[TB] FAIL reset_up_p: got %0d expected 0", up_p); end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_mul();
        logic signed [47:0] got;
        logic signed [47:0] exp;
        logic signed [26:0] ra;
        logic signed [17:0] rb;
        int lat;
        run_op(3'd0, 27'sd100, -18'sd3, 48'sd0, got, lat);
        checks++; if (got !== -48'sd300) begin errors++; $display("[TB] FAIL mul_basic: got %0d expected -300", got); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 3", lat); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mul_pulse: got %b expected 0", valid_o); end
        for (int s = 0; s < 4; s++) begin
            ra = 27'($urandom_range(1, 67108863));
            rb = 18'($urandom_range(1, 131071));
            if (s[0]) ra = -ra;
            if (s[1]) rb = -rb;
            exp = ref_op(0, longint'(ra), longint'(rb), 0, 0, 0);
            run_op(3'd0, ra, rb, 48'sd0, got, lat);
            checks++; if (got !== exp || lat !== 3) begin
                errors++; $display("[TB] FAIL mul_sign%0d: got %0d lat %0d expected %0d lat 3", s, got, lat, exp);
            end
        end
    endtask

    task automatic test_acc_bubbles();
        logic signed [47:0] got;
        int lat;
        run_op(3'd6, 27'sd0, 18'sd0, 48'sd0, got, lat);
        run_op(3'd3, 27'sd5, 18'sd7, 48'sd0, got, lat);
        checks++; if (got !== 48'sd35) begin errors++; $display("[TB] FAIL acc_first: got %0d expected 35", got); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (p !== 48'sd35 || valid_o !== 1'b0) begin
                errors++; $display("[TB] FAIL acc_bubble%0d: got %0d/%b expected 35/0", i, p, valid_o);
            end
        end
        run_op(3'd3, -27'sd2, 18'sd4, 48'sd0, got, lat);
        checks++; if (got !== 48'sd27) begin errors++; $display("[TB] FAIL acc_second: got %0d expected 27", got); end
    endtask

    task automatic test_shift();
        logic signed [47:0] got;
        int lat;
        run_op(3'd0, 27'sd1048576, 18'sd1, 48'sd0, got, lat);
        run_op(3'd4, 27'sd1, 18'sd1, 48'sd0, got, lat);
        checks++; if (got !== 48'sd9) begin errors++; $display("[TB] FAIL shift_acc: got %0d expected 9", got); end
    endtask

    task automatic test_cascade();
        logic signed [47:0] up_exp;
        logic signed [47:0] exp;
        for (int t = 0; t < 2; t++) begin
            up_op = 3'd0;
            up_a = (t == 0) ? 27'sd3 : 27'sd131072;
            up_b = (t == 0) ? 18'sd1000 : -18'sd1;
            up_valid = 1'b1;
            up_exp = ref_op(0, longint'(up_a), longint'(up_b), 0, 0, 0);
            exp = ref_op(5, 1, 1, 0, longint'(up_exp), 0);
            tick();
            up_valid = 1'b0;
            op = 3'd5; a = 27'sd1; b = 18'sd1; valid = 1'b1;
            tick();
            valid = 1'b0;
            tick(); tick();
            checks++; if (p !== exp || valid_o !== 1'b1) begin
                errors++; $display("[TB] FAIL cascade%0d: got %0d/%b expected %0d/1", t, p, valid_o, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic signed [47:0] got;
        int lat;
        run_op(3'd0, 27'h4000000, 18'h20000, 48'sd0, got, lat);
        checks++; if (got !== 48'h0800_0000_0000) begin errors++; $display("[TB] FAIL wrap_extreme: got %0d expected 2^43", got); end
        run_op(3'd1, 27'sd0, 18'sd0, 48'h7FFF_FFFF_FFFF, got, lat);
        run_op(3'd3, 27'sd1, 18'sd1, 48'sd0, got, lat);
        checks++; if (got !== 48'h8000_0000_0000) begin errors++; $display("[TB] FAIL wrap_acc: got %0d expected -2^47", got); end
    endtask

    task automatic test_ce_stall();
        logic signed [47:0] exp;
        int cnt;
        int lat;
        exp = ref_op(0, 1234, -56, 0, 0, 0);
        op = 3'd0; a = 27'sd1234; b = -18'sd56; valid = 1'b1;
        tick();
        cnt = 1;
        ce = 1'b0; op = 3'd6;
        repeat (4) begin tick(); cnt++; end
        ce = 1'b1; valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            if (valid_o === 1'b1) begin lat = cnt; break; end
            tick(); cnt++;
        end
        checks++; if (lat !== 7 || p !== exp) begin
            errors++; $display("[TB] FAIL ce_stall: got lat %0d p %0d expected lat 7 p %0d", lat, p, exp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid_o !== 1'b0 || p !== exp) begin
                errors++; $display("[TB] FAIL ce_ignored%0d: got %0d/%b expected %0d/0", i, p, valid_o, exp);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic signed [47:0] got;
        int lat;
        run_op(3'd0, 27'sd77, 18'sd9, 48'sd0, got, lat);
        op = 3'd0; a = 27'sd11; b = 18'sd13; valid = 1'b1;
        tick(); tick();
        valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (p !== 48'sd0 || valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_async: got %0d/%b expected 0/0", p, valid_o);
        end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (p !== 48'sd0 || valid_o !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_flush%0d: got %0d/%b expected 0/0", i, p, valid_o);
            end
        end
    endtask

    task automatic test_latency_sweep();
        int lat [6];
        logic signed [47:0] got [6];
        logic signed [47:0] exp;
        valid = 1'b0; ce = 1'b1;
        repeat (5) tick();
        a = 27'($urandom); b = 18'($urandom); op = 3'd0; valid = 1'b1;
        exp = ref_op(0, longint'(a), longint'(b), 0, 0, 0);
        tick();
        valid = 1'b0;
        for (int i = 0; i < 6; i++) begin lat[i] = -1; got[i] = '0; end
        for (int k = 1; k <= 6; k++) begin
            for (int i = 0; i < 6; i++) begin
                if (lat[i] < 0 && sw_v[i] === 1'b1) begin lat[i] = k; got[i] = sw_p[i]; end
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (lat[i] !== i / 2 + i % 2 + 1 || got[i] !== exp) begin
                errors++; $display("[TB] FAIL sweep_ab%0d_m%0d: got lat %0d p %0d expected lat %0d p %0d",
                                   i / 2, i % 2, lat[i], got[i], i / 2 + i % 2 + 1, exp);
            end
        end
    endtask

    typedef struct {
        int                 due;
        logic signed [47:0] val;
    } exp_t;

    task automatic test_random();
        exp_t q[$];
        int opsel [6] = '{0, 1, 3, 4, 6, 7};
        logic signed [47:0] got;
        logic signed [47:0] model_p;
        logic signed [47:0] shown_p;
        logic shown_v;
        logic issue;
        int en;
        int lat;
        run_op(3'd6, 27'sd0, 18'sd0, 48'sd0, got, lat);
        checks++; if (got !== 48'sd0) begin errors++; $display("[TB] FAIL rand_clear: got %0d expected 0", got); end
        model_p = '0; shown_p = '0; shown_v = 1'b1; en = 0;
        for (int k = 0; k < 80; k++) begin
            ce = ($urandom_range(0, 4) != 0);
            issue = (k < 60) && ($urandom_range(0, 2) != 0);
            valid = issue;
            op = 3'(opsel[$urandom_range(0, 5)]);
            a = 27'($urandom); b = 18'($urandom);
            c = {16'($urandom), 32'($urandom)};
            tick();
            if (ce) begin
                if (issue) begin
                    model_p = ref_op(int'(op), longint'(a), longint'(b), longint'(c), 0, longint'(model_p));
                    q.push_back('{en + 2, model_p});
                end
                if (q.size() > 0 && q[0].due == en) begin
                    shown_p = q[0].val;
                    shown_v = 1'b1;
                    void'(q.pop_front());
                end else begin
                    shown_v = 1'b0;
                end
                en++;
            end
            checks++; if (p !== shown_p || valid_o !== shown_v) begin
                errors++; $display("[TB] FAIL rand_cycle%0d: got %0d/%b expected %0d/%b", k, p, valid_o, shown_p, shown_v);
            end
        end
        ce = 1'b1; valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_acc_bubbles();
        test_shift();
        test_cascade();
        test_wrap();
        test_ce_stall();
        test_reset_inflight();
        test_latency_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
